// File: rtl/rob_param_if.sv
// Allocate/commit handshake bundle for the reorder buffer.
// master = issue/commit consumer side, slave = the ROB.
interface rob_param_if #(
    parameter int TAGW = 3
);
    logic            alloc_valid;
    logic            alloc_ready;
    logic [4:0]      alloc_rd;
    logic [1:0]      alloc_kind;
    logic [31:0]     alloc_pc;
    logic [TAGW-1:0] alloc_tag;

    logic            commit_valid;
    logic            commit_ready;
    logic [TAGW-1:0] commit_tag;
    logic [4:0]      commit_rd;
    logic [1:0]      commit_kind;
    logic [31:0]     commit_data;
    logic [31:0]     commit_pc;

    modport master (
        output alloc_valid, alloc_rd, alloc_kind, alloc_pc,
        output commit_ready,
        input  alloc_ready, alloc_tag,
        input  commit_valid, commit_tag, commit_rd,
        input  commit_kind, commit_data, commit_pc
    );

    modport slave (
        input  alloc_valid, alloc_rd, alloc_kind, alloc_pc,
        input  commit_ready,
        output alloc_ready, alloc_tag,
        output commit_valid, commit_tag, commit_rd,
        output commit_kind, commit_data, commit_pc
    );
endinterface

// File: rtl/rob_param.sv
// Parameterised in-order reorder buffer: allocate at tail,
// out-of-order multi-port writeback, in-order commit at head.
module rob_param #(
    parameter int DEPTH  = 8,
    parameter int NUM_WB = 5,
    parameter int TAGW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rob_param_if.slave             io,
    input  logic [NUM_WB-1:0]      wb_valid,
    input  logic [NUM_WB*TAGW-1:0] wb_tag,
    input  logic [NUM_WB*32-1:0]   wb_data,
    input  logic [NUM_WB-1:0]      wb_mispredict,
    output logic                   flush,
    output logic [31:0]            redirect_pc,
    output logic [TAGW:0]          count,
    output logic                   wb_err
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [1:0]    KIND_BRANCH = 2'd3;
    localparam logic [TAGW:0] DEPTH_C     = (TAGW+1)'(DEPTH);

    state_t state_q, state_d;

    logic [TAGW-1:0] head_q, tail_q;
    logic [TAGW:0]   count_q;
    logic [31:0]     redir_q;
    logic            err_q;

    logic [DEPTH-1:0] busy_q, done_q, mp_q;
    logic [4:0]       rd_q   [DEPTH];
    logic [1:0]       kind_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic [DEPTH-1:0] wb_hit;
    logic [DEPTH-1:0] wb_sel_mp;
    logic [31:0]      wb_sel_data [DEPTH];
    logic             err_set;

    logic do_alloc, do_commit, squash;

    assign flush          = (state_q == FLUSH);
    assign io.alloc_ready = (count_q < DEPTH_C) && !flush;
    assign io.alloc_tag   = tail_q;
    assign do_alloc       = io.alloc_valid && io.alloc_ready;

    assign io.commit_valid = busy_q[head_q] && done_q[head_q];
    assign do_commit       = io.commit_valid && io.commit_ready;
    assign squash          = do_commit && mp_q[head_q] &&
                             (kind_q[head_q] == KIND_BRANCH);

    assign io.commit_tag  = head_q;
    assign io.commit_rd   = rd_q[head_q];
    assign io.commit_kind = kind_q[head_q];
    assign io.commit_data = data_q[head_q];
    assign io.commit_pc   = pc_q[head_q];

    assign redirect_pc = redir_q;
    assign count       = count_q;
    assign wb_err      = err_q;

    // Scan ports high to low so the lowest port's result lands last.
    always_comb begin
        logic [TAGW-1:0] t;
        t       = '0;
        wb_hit  = '0;
        wb_sel_mp = '0;
        err_set = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            wb_sel_data[j] = '0;
        end
        for (int i = NUM_WB-1; i >= 0; i--) begin
            if (wb_valid[i] && !flush) begin
                t = wb_tag[i*TAGW +: TAGW];
                if (busy_q[t]) begin
                    wb_hit[t]      = 1'b1;
                    wb_sel_data[t] = wb_data[i*32 +: 32];
                    wb_sel_mp[t]   = wb_mispredict[i];
                end else begin
                    err_set = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (squash) state_d = FLUSH;
            FLUSH: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            redir_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_q | err_set;
            if (squash) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                redir_q <= data_q[head_q];
            end else begin
                if (do_alloc)  tail_q <= tail_q + TAGW'(1);
                if (do_commit) head_q <= head_q + TAGW'(1);
                count_q <= count_q
                         + {{TAGW{1'b0}}, do_alloc}
                         - {{TAGW{1'b0}}, do_commit};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            done_q <= '0;
            mp_q   <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                rd_q[j]   <= '0;
                kind_q[j] <= '0;
                pc_q[j]   <= '0;
                data_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (squash) begin
                    busy_q[j] <= 1'b0;
                    done_q[j] <= 1'b0;
                    mp_q[j]   <= 1'b0;
                end else if (do_alloc && tail_q == TAGW'(j)) begin
                    busy_q[j] <= 1'b1;
                    done_q[j] <= 1'b0;
                    mp_q[j]   <= 1'b0;
                    rd_q[j]   <= io.alloc_rd;
                    kind_q[j] <= io.alloc_kind;
                    pc_q[j]   <= io.alloc_pc;
                end else if (do_commit && head_q == TAGW'(j)) begin
                    busy_q[j] <= 1'b0;
                    done_q[j] <= 1'b0;
                    mp_q[j]   <= 1'b0;
                end else if (wb_hit[j]) begin
                    done_q[j] <= 1'b1;
                    mp_q[j]   <= wb_sel_mp[j];
                    data_q[j] <= wb_sel_data[j];
                end
            end
        end
    end

endmodule
